edge_mask_streamer: RTL and testbench
=====================================

// Module: edge_mask_streamer
// PURPOSE
//  Transmit side of the edge_mask/data_sel slice protocol. Holds a 2048-bit edge pattern,
//  loaded as 64 x 32-bit words through a shadow buffer. Drives one 64-bit edge_mask slice
//  per cycle, locked to the collector's free-running data_sel counter (0..31), so each
//  collector frame receives the full pattern. Adds frame counting and sync-error detection.
// PARAMETERS
//  WORD_W      32    width of the write-port word
//  SLICE_W     64    width of edge_mask (one slice)
//  NUM_SLICES  32    slices per frame; pattern width = SLICE_W*NUM_SLICES = 2048
// PORTS
//  CLK          in   1   clock; all logic on posedge
//  RST_n        in   1   reset, asynchronous, active-low
//  wr_en        in   1   write shadow word wr_addr with wr_data
//  wr_addr      in   6   word index 0..63; writes shadow[32*wr_addr+31 : 32*wr_addr]
//  wr_data      in   32  write data
//  commit       in   1   pulse: request copy of shadow buffer into active buffer
//  commit_pend  out  1   commit requested but not yet applied
//  start        in   1   pulse: begin streaming (also clears sync_err)
//  stop         in   1   pulse: stop streaming after the current frame
//  data_sel     in   5   slot index from the collector
//  edge_mask    out  64  registered slice output
//  busy         out  1   state != IDLE
//  frame_done   out  1   1-cycle pulse on the cycle the last slice (data_sel==31) is driven
//  frame_cnt    out  16  completed frames, wraps 0xFFFF->0
//  sync_err     out  1   sticky flag: data_sel deviated from the expected slot
// BEHAVIOUR
//  Reset: all state cleared. Buffers = 0, edge_mask = 0, frame_cnt = 0, all flags 0, state IDLE.
//  Slice mapping: slice k = active[2047-64k -: 64] = {word(63-2k), word(62-2k)}.
//   - With this mapping, collector bit i equals active bit i.
//   - Collector readback word (sel1*16+sel2) therefore equals wr_addr.
//  Alignment: edge_mask is a register. In STREAM it is loaded with slice((data_sel+1) mod 32),
//   so during the cycle data_sel==k the output holds slice k.
//  Outside STREAM, edge_mask = 0. This is harmless to the OR-accumulating collector.
//  FSM:
//   IDLE  : start -> SYNC.
//   SYNC  : wait for data_sel==31. On that cycle load slice 0, set expected slot = 0, go STREAM.
//           stop -> IDLE.
//   STREAM: each cycle, expected slot increments mod 32.
//           data_sel != expected slot -> sync_err=1, edge_mask loads 0, go SYNC.
//           On data_sel==31: frame_done=1 and frame_cnt+1.
//           On data_sel==31 with stop latched: go IDLE, edge_mask loads 0.
//  stop: latched while in STREAM and cleared on leaving STREAM.
//   - stop and start in the same cycle: stop wins.
//   - start while busy is ignored, except that it clears sync_err.
//  commit: sets commit_pend. The copy is applied on the first cycle where commit_pend=1 and
//   either state != STREAM, or state==STREAM with data_sel==31 (frame boundary).
//   - In STREAM, the frame boundary load of slice 0 uses the new contents.
//   - A frame in progress always completes with the old pattern.
//   - The copy uses shadow contents as of that cycle; a wr_en in the same cycle lands after the copy.
//   - commit_pend clears when the copy is applied. commit while pending: no extra effect.
//  Writes: accepted every cycle in any state; they affect only the shadow buffer.
//  Reset mid-operation: asynchronous. All state, including buffers and pending commit, clears immediately.
// TESTING
//  1. Assert RST_n=0 during STREAM at data_sel=17 -> same cycle edge_mask=0, busy=0, frame_cnt=0,
//     commit_pend=0, sync_err=0.
//  2. Write word a = 0xA5000000|a for a=0..63, commit, start; collector data_sel free-running ->
//     data_sel=0: edge_mask = 0xA500003F_A500003E; data_sel=31: 0xA5000001_A5000000;
//     frame_done pulses; frame_cnt=1; collector readback of word a = 0xA5000000|a.
//  3. In STREAM, rewrite all words with 0x5A000000|a and commit at data_sel=10 ->
//     commit_pend=1 until data_sel=31; the rest of that frame uses old values;
//     next data_sel=0 drives 0x5A00003F_5A00003E.
//  4. Force data_sel jump 12->20 during STREAM -> sync_err=1, edge_mask=0 next cycle,
//     resync at next 31->0 wrap; sync_err stays 1 until start.
//  5. stop at data_sel=5 -> slices 6..31 still driven, frame_done pulses, frame_cnt+1,
//     then IDLE, busy=0, edge_mask=0.
//  6. frame_cnt preset via 65535 frames -> next frame_done wraps frame_cnt to 0.

Source files
------------

// File: rtl/edge_mask_streamer.sv
`default_nettype none
// ============================================================================
// edge_mask_streamer
// Streams a 2048-bit edge pattern as 64-bit slices locked to the collector's
// free-running data_sel slot counter, with shadow/active double buffering.
// Rev 1.0
// ============================================================================
module edge_mask_streamer #(
    parameter int WORD_W     = 32,
    parameter int SLICE_W    = 64,
    parameter int NUM_SLICES = 32
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               wr_en,
    input  logic [5:0]         wr_addr,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic               commit,
    output logic               commit_pend,
    input  logic               start,
    input  logic               stop,
    input  logic [4:0]         data_sel,
    output logic [SLICE_W-1:0] edge_mask,
    output logic               busy,
    output logic               frame_done,
    output logic [15:0]        frame_cnt,
    output logic               sync_err
);
    localparam int         PAT_W     = SLICE_W * NUM_SLICES;
    localparam logic [4:0] LAST_SLOT = 5'(NUM_SLICES - 1);
    localparam logic [4:0] PRE_LAST  = 5'(NUM_SLICES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t             state;
    logic [PAT_W-1:0]   shadow;
    logic [PAT_W-1:0]   active;
    logic [PAT_W-1:0]   src;
    logic [4:0]         exp_slot;
    logic [4:0]         next_idx;
    logic [4:0]         rev_idx;
    logic               stop_lat;
    logic               apply;
    logic [SLICE_W-1:0] next_slice;

    // A commit applied this cycle must already feed the slice loaded at the
    // frame boundary, so the slice source bypasses the active buffer.
    assign apply      = commit_pend && ((state != STREAM) || (data_sel == LAST_SLOT));
    assign src        = apply ? shadow : active;
    assign next_idx   = data_sel + 5'd1;
    assign rev_idx    = LAST_SLOT - next_idx;
    assign next_slice = src[rev_idx*SLICE_W +: SLICE_W];
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            shadow      <= '0;
            active      <= '0;
            exp_slot    <= '0;
            stop_lat    <= 1'b0;
            commit_pend <= 1'b0;
            edge_mask   <= '0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            sync_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (wr_en)
                shadow[wr_addr*WORD_W +: WORD_W] <= wr_data;

            if (apply) begin
                active      <= shadow;
                commit_pend <= 1'b0;
            end else if (commit) begin
                commit_pend <= 1'b1;
            end

            if (start)
                sync_err <= 1'b0;

            case (state)
                IDLE: begin
                    edge_mask <= '0;
                    if (start && !stop)
                        state <= SYNC;
                end
                SYNC: begin
                    edge_mask <= '0;
                    if (stop) begin
                        state <= IDLE;
                    end else if (data_sel == LAST_SLOT) begin
                        edge_mask <= next_slice;
                        exp_slot  <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (stop)
                        stop_lat <= 1'b1;
                    if (data_sel != exp_slot) begin
                        sync_err  <= 1'b1;
                        edge_mask <= '0;
                        stop_lat  <= 1'b0;
                        state     <= SYNC;
                    end else begin
                        exp_slot  <= exp_slot + 5'd1;
                        edge_mask <= next_slice;
                        // Registered so the pulse and new count coincide with the last slice.
                        if (data_sel == PRE_LAST) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end
                        if ((data_sel == LAST_SLOT) && (stop || stop_lat)) begin
                            edge_mask <= '0;
                            stop_lat  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    edge_mask <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_edge_mask_streamer.sv
`default_nettype none
// ============================================================================
// tb_edge_mask_streamer
// Directed bench: free-running collector slot counter, hand-derived slices.
// Rev 1.0
// ============================================================================
module tb_edge_mask_streamer;
    logic        CLK = 1'b0;
    logic        RST_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit;
    logic        commit_pend;
    logic        start;
    logic        stop;
    logic [4:0]  data_sel;
    logic [63:0] edge_mask;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        sync_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2047:0] coll;

    always #5 CLK = ~CLK;

    edge_mask_streamer dut (
        .CLK(CLK), .RST_n(RST_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .commit_pend(commit_pend), .start(start), .stop(stop),
        .data_sel(data_sel), .edge_mask(edge_mask), .busy(busy), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .sync_err(sync_err)
    );

    // Slice k of a pattern whose word a is (pat | a): {word(63-2k), word(62-2k)}.
    function automatic logic [63:0] exp_slice(input logic [31:0] pat, input int k);
        return {pat | 32'(63 - 2*k), pat | 32'(62 - 2*k)};
    endfunction

    // One clock: outputs settle, collector slot advances, single-cycle pulses drop.
    task automatic adv();
        @(posedge CLK);
        #1;
        data_sel = data_sel + 5'd1;
        wr_en = 1'b0; commit = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (edge_mask !== 64'd0) begin n_fail++; $display("FAIL reset_edge_mask: got %h expected 0", edge_mask); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt); end
        n_checks++; if (commit_pend !== 1'b0) begin n_fail++; $display("FAIL reset_commit_pend: got %b expected 0", commit_pend); end
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    endtask

    task automatic test_load_stream();
        for (int a = 0; a < 64; a++) begin
            wr_en = 1'b1; wr_addr = 6'(a); wr_data = 32'hA500_0000 | 32'(a);
            adv();
        end
        commit = 1'b1;
        adv();
        n_checks++; if (commit_pend !== 1'b1) begin n_fail++; $display("FAIL idle_commit_pend_set: got %b expected 1", commit_pend); end
        adv();
        n_checks++; if (commit_pend !== 1'b0) begin n_fail++; $display("FAIL idle_commit_applied: got %b expected 0", commit_pend); end
        while (data_sel != 5'd5) adv();
        start = 1'b1;
        adv();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b expected 1", busy); end
        while (data_sel != 5'd0) adv();
        coll = '0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) adv();
            n_checks++; if (edge_mask !== exp_slice(32'hA500_0000, k)) begin n_fail++; $display("FAIL load_slice%0d: got %h expected %h", k, edge_mask, exp_slice(32'hA500_0000, k)); end
            n_checks++; if (frame_done !== (k == 31)) begin n_fail++; $display("FAIL load_frame_done%0d: got %b expected %b", k, frame_done, (k == 31)); end
            coll[(31-k)*64 +: 64] = coll[(31-k)*64 +: 64] | edge_mask;
        end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL load_frame_cnt: got %0d expected 1", frame_cnt); end
        for (int a = 0; a < 64; a++) begin
            n_checks++; if (coll[a*32 +: 32] !== (32'hA500_0000 | 32'(a))) begin n_fail++; $display("FAIL readback_word%0d: got %h expected %h", a, coll[a*32 +: 32], 32'hA500_0000 | 32'(a)); end
        end
    endtask

    task automatic test_commit_boundary();
        adv();
        for (int a = 0; a < 64; a++) begin
            n_checks++; if (edge_mask !== exp_slice(32'hA500_0000, int'(data_sel))) begin n_fail++; $display("FAIL rewrite_old_slice%0d: got %h expected %h", data_sel, edge_mask, exp_slice(32'hA500_0000, int'(data_sel))); end
            wr_en = 1'b1; wr_addr = 6'(a); wr_data = 32'h5A00_0000 | 32'(a);
            adv();
        end
        while (data_sel != 5'd10) adv();
        commit = 1'b1;
        for (int k = 11; k < 32; k++) begin
            adv();
            n_checks++; if (commit_pend !== 1'b1) begin n_fail++; $display("FAIL stream_commit_pend%0d: got %b expected 1", k, commit_pend); end
            n_checks++; if (edge_mask !== exp_slice(32'hA500_0000, k)) begin n_fail++; $display("FAIL frame_keeps_old%0d: got %h expected %h", k, edge_mask, exp_slice(32'hA500_0000, k)); end
        end
        n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL commit_frame_cnt: got %0d expected 4", frame_cnt); end
        adv();
        n_checks++; if (commit_pend !== 1'b0) begin n_fail++; $display("FAIL boundary_commit_clear: got %b expected 0", commit_pend); end
        n_checks++; if (edge_mask !== 64'h5A00003F_5A00003E) begin n_fail++; $display("FAIL boundary_new_slice0: got %h expected 5a00003f5a00003e", edge_mask); end
    endtask

    task automatic test_sync_err();
        while (data_sel != 5'd12) adv();
        adv();
        data_sel = 5'd20;
        n_checks++; if (edge_mask !== exp_slice(32'h5A00_0000, 13)) begin n_fail++; $display("FAIL jump_cycle_slice: got %h expected %h", edge_mask, exp_slice(32'h5A00_0000, 13)); end
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL jump_cycle_sync_err: got %b expected 0", sync_err); end
        adv();
        n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL jump_sync_err: got %b expected 1", sync_err); end
        n_checks++; if (edge_mask !== 64'd0) begin n_fail++; $display("FAIL jump_edge_mask: got %h expected 0", edge_mask); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL jump_busy: got %b expected 1", busy); end
        while (data_sel != 5'd31) adv();
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL resync_no_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL resync_frame_cnt: got %0d expected 4", frame_cnt); end
        for (int k = 0; k < 32; k++) begin
            adv();
            n_checks++; if (edge_mask !== exp_slice(32'h5A00_0000, k)) begin n_fail++; $display("FAIL resync_slice%0d: got %h expected %h", k, edge_mask, exp_slice(32'h5A00_0000, k)); end
        end
        n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_sticky: got %b expected 1", sync_err); end
        n_checks++; if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL resync_frame_cnt_inc: got %0d expected 5", frame_cnt); end
        start = 1'b1;
        adv();
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL start_clears_sync_err: got %b expected 0", sync_err); end
        n_checks++; if (edge_mask !== exp_slice(32'h5A00_0000, 0)) begin n_fail++; $display("FAIL start_while_busy_slice: got %h expected %h", edge_mask, exp_slice(32'h5A00_0000, 0)); end
    endtask

    task automatic test_async_reset();
        while (data_sel != 5'd16) adv();
        commit = 1'b1;
        adv();
        n_checks++; if (commit_pend !== 1'b1) begin n_fail++; $display("FAIL prereset_commit_pend: got %b expected 1", commit_pend); end
        RST_n = 1'b0;
        #1;
        n_checks++; if (edge_mask !== 64'd0) begin n_fail++; $display("FAIL areset_edge_mask: got %h expected 0", edge_mask); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", busy); end
        n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_frame_cnt: got %0d expected 0", frame_cnt); end
        n_checks++; if (commit_pend !== 1'b0) begin n_fail++; $display("FAIL areset_commit_pend: got %b expected 0", commit_pend); end
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL areset_sync_err: got %b expected 0", sync_err); end
        adv();
        RST_n = 1'b1;
        start = 1'b1;
        adv();
        while (data_sel != 5'd0) adv();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL postreset_busy: got %b expected 1", busy); end
        n_checks++; if (edge_mask !== 64'd0) begin n_fail++; $display("FAIL postreset_active_cleared: got %h expected 0", edge_mask); end
        stop = 1'b1;
        while (data_sel != 5'd31) adv();
        adv();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL postreset_stopped: got %b expected 0", busy); end
    endtask

    task automatic test_stop();
        for (int a = 0; a < 64; a++) begin
            wr_en = 1'b1; wr_addr = 6'(a); wr_data = 32'hC300_0000 | 32'(a);
            adv();
        end
        commit = 1'b1;
        adv();
        adv();
        while (data_sel != 5'd5) adv();
        start = 1'b1;
        adv();
        while (data_sel != 5'd5) adv();
        stop = 1'b1;
        for (int k = 6; k < 32; k++) begin
            adv();
            n_checks++; if (edge_mask !== exp_slice(32'hC300_0000, k)) begin n_fail++; $display("FAIL stop_slice%0d: got %h expected %h", k, edge_mask, exp_slice(32'hC300_0000, k)); end
        end
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL stop_frame_done: got %b expected 1", frame_done); end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL stop_frame_cnt: got %0d expected 2", frame_cnt); end
        adv();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got %b expected 0", busy); end
        n_checks++; if (edge_mask !== 64'd0) begin n_fail++; $display("FAIL stop_edge_mask: got %h expected 0", edge_mask); end
        adv();
        n_checks++; if (edge_mask !== 64'd0) begin n_fail++; $display("FAIL idle_edge_mask: got %h expected 0", edge_mask); end
    endtask

    task automatic test_wrap();
        start = 1'b1; stop = 1'b1;
        adv();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_wins_over_start: got %b expected 0", busy); end
        start = 1'b1;
        adv();
        while (data_sel != 5'd0) adv();
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        adv();
        n_checks++; if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset: got %h expected ffff", frame_cnt); end
        while (data_sel != 5'd31) adv();
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL wrap_frame_done: got %b expected 1", frame_done); end
        n_checks++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_frame_cnt: got %h expected 0000", frame_cnt); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; start = 1'b0; stop = 1'b0; data_sel = '0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        RST_n = 1'b1;
        test_load_stream();
        test_commit_boundary();
        test_sync_err();
        test_async_reset();
        test_stop();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
